eye_width_sweep: RTL and testbench



---
 rtl/eye_width_sweep_pkg.sv | 27 ++
 rtl/eye_window_tracker.sv | 85 ++++++++
 rtl/eye_width_sweep.sv | 211 +++++++++++++++++++++
 tb/tb_eye_width_sweep.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eye_width_sweep_pkg.sv
// eye_width_sweep_pkg
//   Shared definitions for the eye-width sweep block: FSM state encoding,
//   default sizing constants and the mainband/valtrain test-select encoding.
//   Imported by eye_width_sweep and eye_window_tracker.
package eye_width_sweep_pkg;

  // Default sizing: 16 data lanes, 4-bit PI code swept 0..15, 4 settle cycles.
  localparam int DEF_NUM_LANES  = 16;
  localparam int DEF_PI_W       = 4;
  localparam int DEF_PI_MAX     = 15;
  localparam int DEF_SETTLE_CYC = 4;

  // Encoding of i_mainband_or_valtrain_test.
  localparam logic TEST_MAINBAND = 1'b0;
  localparam logic TEST_VALTRAIN = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_EVAL   = 3'd4,
    ST_CENTER = 3'd5,
    ST_DONE   = 3'd6
  } ews_state_e;

endpackage

// File: rtl/eye_window_tracker.sv
// eye_window_tracker
//   Tracks the longest contiguous run of passing PI codes seen during a sweep
//   and reports the centre code of that run.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clear         zero all window registers (start of a new sweep)
//   step          one PI code has been evaluated this cycle
//   pass          result of the code being evaluated
//   code          PI code being evaluated
//   best_start    first code of the longest passing window
//   best_len      length of that window (0 = no passing code yet)
//   center        best_start + floor((best_len-1)/2); meaningful when best_len != 0
module eye_window_tracker
  import eye_width_sweep_pkg::*;
#(
  parameter int PI_W = DEF_PI_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            step,
  input  logic            pass,
  input  logic [PI_W-1:0] code,
  output logic [PI_W-1:0] best_start,
  output logic [PI_W:0]   best_len,
  output logic [PI_W-1:0] center
);

  localparam int LEN_W = PI_W + 1;

  logic [PI_W-1:0]  cur_start_q, cur_start_d;
  logic [LEN_W-1:0] cur_len_q, cur_len_d;
  logic [PI_W-1:0]  best_start_q, best_start_d;
  logic [LEN_W-1:0] best_len_q, best_len_d;

  // Extend the current run on a pass, break it on a fail. The best window is
  // only replaced on a strictly longer run, so the earliest of equal-length
  // windows is kept.
  always_comb begin
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    if (clear) begin
      cur_start_d  = '0;
      cur_len_d    = '0;
      best_start_d = '0;
      best_len_d   = '0;
    end else if (step) begin
      if (pass) begin
        if (cur_len_q == '0) begin
          cur_start_d = code;
        end
        cur_len_d = cur_len_q + LEN_W'(1);
        if (cur_len_d > best_len_q) begin
          best_start_d = cur_start_d;
          best_len_d   = cur_len_d;
        end
      end else begin
        cur_len_d = '0;
      end
    end
  end

  // Window registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else begin
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
    end
  end

  assign best_start = best_start_q;
  assign best_len   = best_len_q;
  // The window lies inside 0..PI_MAX, so the centre always fits PI_W bits.
  assign center     = best_start_q + PI_W'((best_len_q - LEN_W'(1)) >> 1);

endmodule

// File: rtl/eye_width_sweep.sv
// eye_width_sweep
//   Sweeps the PI phase code 0..PI_MAX, launches one point test per code,
//   finds the longest passing window and parks the PI at its centre, then
//   acknowledges the centre-cal controller.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_en                          level enable from the centre-cal controller
//   i_mainband_or_valtrain_test   0 = all lanes must pass, 1 = lane 0 only
//   i_pt_done                     1-cycle point-test completion pulse
//   i_pt_lanes_result             per-lane pass vector, valid with i_pt_done
//   o_pt_start                    1-cycle point-test launch pulse
//   o_pi_step                     PI control word
//   o_busy                        high from sweep start until ack
//   o_test_ack                    sweep complete, held until i_en falls
//   o_center_valid                a passing window was found
//   o_tx_lanes_result             OR of all lane vectors seen in the sweep
module eye_width_sweep
  import eye_width_sweep_pkg::*;
#(
  parameter int NUM_LANES  = DEF_NUM_LANES,
  parameter int PI_W       = DEF_PI_W,
  parameter int PI_MAX     = DEF_PI_MAX,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic                 i_mainband_or_valtrain_test,
  input  logic                 i_pt_done,
  input  logic [NUM_LANES-1:0] i_pt_lanes_result,
  output logic                 o_pt_start,
  output logic [PI_W-1:0]      o_pi_step,
  output logic                 o_busy,
  output logic                 o_test_ack,
  output logic                 o_center_valid,
  output logic [NUM_LANES-1:0] o_tx_lanes_result
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [PI_W-1:0]  PI_LAST     = PI_W'(PI_MAX);

  ews_state_e           state_q, state_d;
  logic [CNT_W-1:0]     settle_cnt_q, settle_cnt_d;
  logic                 centring_q, centring_d;
  logic [PI_W-1:0]      pi_q, pi_d;
  logic                 busy_q, busy_d;
  logic                 ack_q, ack_d;
  logic                 cv_q, cv_d;
  logic                 pt_start_q, pt_start_d;
  logic [NUM_LANES-1:0] tx_q, tx_d;
  logic [NUM_LANES-1:0] pt_vec_q, pt_vec_d;

  logic                 pass;
  logic                 win_clear;
  logic                 win_step;
  logic [PI_W-1:0]      unused_best_start;
  logic [PI_W:0]        best_len;
  logic [PI_W-1:0]      center;

  // Pass criterion for the vector captured in WAIT: every lane in mainband
  // mode, only the valid lane (bit 0) in valtrain mode.
  assign pass = (i_mainband_or_valtrain_test == TEST_VALTRAIN) ? pt_vec_q[0] : &pt_vec_q;

  assign win_clear = (state_q == ST_IDLE) && i_en;
  assign win_step  = (state_q == ST_EVAL);

  eye_window_tracker #(
    .PI_W (PI_W)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .clear      (win_clear),
    .step       (win_step),
    .pass       (pass),
    .code       (pi_q),
    .best_start (unused_best_start),
    .best_len   (best_len),
    .center     (center)
  );

  // Next-state and next-output logic. All outputs are registered; each
  // transition sets the values the outputs must show in the next state.
  // A dropped enable outside IDLE/DONE overrides the normal transition.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    centring_d   = centring_q;
    pi_d         = pi_q;
    busy_d       = busy_q;
    ack_d        = ack_q;
    cv_d         = cv_q;
    pt_start_d   = 1'b0;
    tx_d         = tx_q;
    pt_vec_d     = pt_vec_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_en) begin
          tx_d         = '0;
          cv_d         = 1'b0;
          pi_d         = '0;
          busy_d       = 1'b1;
          ack_d        = 1'b0;
          centring_d   = 1'b0;
          settle_cnt_d = '0;
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          settle_cnt_d = '0;
          if (centring_q) begin
            busy_d  = 1'b0;
            ack_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            pt_start_d = 1'b1;
            state_d    = ST_START;
          end
        end else begin
          settle_cnt_d = settle_cnt_q + CNT_W'(1);
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_pt_done) begin
          pt_vec_d = i_pt_lanes_result;
          state_d  = ST_EVAL;
        end
      end
      ST_EVAL: begin
        tx_d = tx_q | pt_vec_q;
        if (pi_q == PI_LAST) begin
          state_d = ST_CENTER;
        end else begin
          pi_d    = pi_q + PI_W'(1);
          state_d = ST_SETTLE;
        end
      end
      ST_CENTER: begin
        if (best_len != '0) begin
          pi_d = center;
          cv_d = 1'b1;
        end else begin
          pi_d = '0;
          cv_d = 1'b0;
        end
        centring_d = 1'b1;
        state_d    = ST_SETTLE;
      end
      ST_DONE: begin
        if (!i_en) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!i_en && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
      state_d      = ST_IDLE;
      busy_d       = 1'b0;
      ack_d        = 1'b0;
      pi_d         = '0;
      cv_d         = 1'b0;
      pt_start_d   = 1'b0;
      settle_cnt_d = '0;
      centring_d   = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      centring_q   <= 1'b0;
      pi_q         <= '0;
      busy_q       <= 1'b0;
      ack_q        <= 1'b0;
      cv_q         <= 1'b0;
      pt_start_q   <= 1'b0;
      tx_q         <= '0;
      pt_vec_q     <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      centring_q   <= centring_d;
      pi_q         <= pi_d;
      busy_q       <= busy_d;
      ack_q        <= ack_d;
      cv_q         <= cv_d;
      pt_start_q   <= pt_start_d;
      tx_q         <= tx_d;
      pt_vec_q     <= pt_vec_d;
    end
  end

  assign o_pt_start        = pt_start_q;
  assign o_pi_step         = pi_q;
  assign o_busy            = busy_q;
  assign o_test_ack        = ack_q;
  assign o_center_valid    = cv_q;
  assign o_tx_lanes_result = tx_q;

endmodule

// File: tb/tb_eye_width_sweep.sv
// tb_eye_width_sweep
//   Self-checking bench for eye_width_sweep: a table of directed sweeps,
//   abort and reset corner cases, and randomized sweeps compared against a
//   window-search model. A responder process plays the point-test block.
module tb_eye_width_sweep;
  import eye_width_sweep_pkg::*;

  localparam int NL     = 16;
  localparam int PW     = 4;
  localparam int PM     = 15;
  localparam int SC     = 4;
  localparam int NCODES = PM + 1;

  typedef struct {
    string           name;
    logic            mode;
    logic [NCODES-1:0] pass_mask;
    logic [NL-1:0]   pass_vec;
    logic [NL-1:0]   fail_vec;
    logic [PW-1:0]   exp_pi;
    logic            exp_cv;
    logic [NL-1:0]   exp_tx;
  } vec_rec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_en;
  logic          mode;
  logic          i_pt_done;
  logic [NL-1:0] i_pt_lanes_result;
  logic          o_pt_start;
  logic [PW-1:0] o_pi_step;
  logic          o_busy;
  logic          o_test_ack;
  logic          o_center_valid;
  logic [NL-1:0] o_tx_lanes_result;

  logic          resp_done;
  logic          man_done;
  logic [NL-1:0] vec_tbl [NCODES];
  bit            responder_en;
  int            hold_code;
  int            pt_count;
  int            errors;
  int            checks;

  assign i_pt_done = resp_done | man_done;

  always #5 clk = ~clk;

  eye_width_sweep #(
    .NUM_LANES  (NL),
    .PI_W       (PW),
    .PI_MAX     (PM),
    .SETTLE_CYC (SC)
  ) dut (
    .clk                         (clk),
    .rst                         (rst),
    .i_en                        (i_en),
    .i_mainband_or_valtrain_test (mode),
    .i_pt_done                   (i_pt_done),
    .i_pt_lanes_result           (i_pt_lanes_result),
    .o_pt_start                  (o_pt_start),
    .o_pi_step                   (o_pi_step),
    .o_busy                      (o_busy),
    .o_test_ack                  (o_test_ack),
    .o_center_valid              (o_center_valid),
    .o_tx_lanes_result           (o_tx_lanes_result)
  );

  // Point-test responder: answers each launch after a random delay with the
  // vector assigned to the PI code that was active at launch.
  initial begin
    logic [PW-1:0] code;
    int lat;
    resp_done = 1'b0;
    i_pt_lanes_result = '0;
    forever begin
      @(posedge clk);
      #1;
      if (o_pt_start === 1'b1 && responder_en && int'(o_pi_step) != hold_code) begin
        code = o_pi_step;
        lat = $urandom_range(0, 3);
        repeat (lat + 1) @(posedge clk);
        #1;
        resp_done = 1'b1;
        i_pt_lanes_result = vec_tbl[code];
        @(posedge clk);
        #1;
        resp_done = 1'b0;
        i_pt_lanes_result = NL'($urandom);
      end
    end
  end

  // Launch-pulse counter.
  initial begin
    pt_count = 0;
    forever begin
      @(posedge clk);
      #2;
      if (o_pt_start === 1'b1) pt_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Runs one sweep with the current vec_tbl until ack or timeout.
  task automatic applyStimulus(input logic m, output bit got_ack, output bit busy_fell, output int npulses);
    int base;
    logic busy_prev;
    base = pt_count;
    busy_prev = 1'b0;
    got_ack = 1'b0;
    busy_fell = 1'b0;
    mode = m;
    i_en = 1'b1;
    for (int c = 0; c < 3000 && !got_ack; c++) begin
      tick();
      if (o_test_ack === 1'b1) begin
        got_ack = 1'b1;
        busy_fell = (o_busy === 1'b0) && (busy_prev === 1'b1);
      end
      busy_prev = o_busy;
    end
    npulses = pt_count - base;
  endtask

  task automatic checkSweep(input string name, input logic m, input logic [PW-1:0] exp_pi,
                            input logic exp_cv, input logic [NL-1:0] exp_tx);
    bit got_ack;
    bit busy_fell;
    int npulses;
    applyStimulus(m, got_ack, busy_fell, npulses);
    checkOutput({name, "_ack"}, 32'(got_ack), 32'd1);
    checkOutput({name, "_busy_fall"}, 32'(busy_fell), 32'd1);
    checkOutput({name, "_pulses"}, 32'(npulses), 32'(NCODES));
    checkOutput({name, "_pi"}, 32'(o_pi_step), 32'(exp_pi));
    checkOutput({name, "_cv"}, 32'(o_center_valid), 32'(exp_cv));
    checkOutput({name, "_tx"}, 32'(o_tx_lanes_result), 32'(exp_tx));
    repeat (3) tick();
    checkOutput({name, "_ack_hold"}, 32'(o_test_ack), 32'd1);
    i_en = 1'b0;
    tick();
    checkOutput({name, "_ack_drop"}, 32'(o_test_ack), 32'd0);
    checkOutput({name, "_busy_idle"}, 32'(o_busy), 32'd0);
    checkOutput({name, "_pi_kept"}, 32'(o_pi_step), 32'(exp_pi));
    checkOutput({name, "_tx_kept"}, 32'(o_tx_lanes_result), 32'(exp_tx));
    tick();
  endtask

  // Reference: choose the longest all-passing window by brute force over
  // every (start, end) pair, earliest start winning ties.
  function automatic void model(input logic m, output logic [PW-1:0] pi,
                                output logic cv, output logic [NL-1:0] tx);
    bit p [NCODES];
    int best_len;
    int best_s;
    bit all_ok;
    tx = '0;
    for (int c = 0; c < NCODES; c++) begin
      p[c] = m ? vec_tbl[c][0] : (vec_tbl[c] == {NL{1'b1}});
      tx |= vec_tbl[c];
    end
    best_len = 0;
    best_s = 0;
    for (int s = 0; s < NCODES; s++) begin
      for (int e = s; e < NCODES; e++) begin
        all_ok = 1'b1;
        for (int k = s; k <= e; k++) all_ok &= p[k];
        if (all_ok && (e - s + 1) > best_len) begin
          best_len = e - s + 1;
          best_s = s;
        end
      end
    end
    cv = (best_len > 0);
    pi = cv ? PW'(best_s + (best_len - 1) / 2) : '0;
  endfunction

  task automatic fillAll(input logic [NL-1:0] v);
    for (int c = 0; c < NCODES; c++) vec_tbl[c] = v;
  endtask

  initial begin
    vec_rec_t tbl [10];
    logic [PW-1:0] mpi;
    logic mcv;
    logic [NL-1:0] mtx;
    logic [NL-1:0] v;
    bit found;
    int base;
    int busy_seen;
    logic rm;

    errors = 0;
    checks = 0;
    responder_en = 1'b1;
    hold_code = -1;
    man_done = 1'b0;
    rst = 1'b1;
    i_en = 1'b0;
    mode = 1'b0;
    fillAll('1);

    tbl[0] = '{"all_pass",   1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 4'd7,  1'b1, 16'hFFFF};
    tbl[1] = '{"win_4_9",    1'b0, 16'h03F0, 16'hFFFF, 16'h7FFF, 4'd6,  1'b1, 16'hFFFF};
    tbl[2] = '{"two_win",    1'b0, 16'h3C1C, 16'hFFFF, 16'h0000, 4'd11, 1'b1, 16'hFFFF};
    tbl[3] = '{"tie",        1'b0, 16'h070E, 16'hFFFF, 16'h1234, 4'd2,  1'b1, 16'hFFFF};
    tbl[4] = '{"valtrain",   1'b1, 16'h0060, 16'h0001, 16'hFFFE, 4'd5,  1'b1, 16'hFFFF};
    tbl[5] = '{"none_pass",  1'b0, 16'h0000, 16'hFFFF, 16'hFFF7, 4'd0,  1'b0, 16'hFFF7};
    tbl[6] = '{"only_15",    1'b0, 16'h8000, 16'hFFFF, 16'h0F0F, 4'd15, 1'b1, 16'hFFFF};
    tbl[7] = '{"only_0",     1'b0, 16'h0001, 16'hFFFF, 16'h0000, 4'd0,  1'b1, 16'hFFFF};
    tbl[8] = '{"val_none",   1'b1, 16'h0000, 16'hFFFF, 16'hFFFE, 4'd0,  1'b0, 16'hFFFE};
    tbl[9] = '{"win_1_15",   1'b0, 16'hFFFE, 16'hFFFF, 16'h0000, 4'd8,  1'b1, 16'hFFFF};

    repeat (3) tick();
    checkOutput("rst_pt_start", 32'(o_pt_start), 32'd0);
    checkOutput("rst_pi", 32'(o_pi_step), 32'd0);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_ack", 32'(o_test_ack), 32'd0);
    checkOutput("rst_cv", 32'(o_center_valid), 32'd0);
    checkOutput("rst_tx", 32'(o_tx_lanes_result), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < NCODES; c++)
        vec_tbl[c] = tbl[i].pass_mask[c] ? tbl[i].pass_vec : tbl[i].fail_vec;
      checkSweep(tbl[i].name, tbl[i].mode, tbl[i].exp_pi, tbl[i].exp_cv, tbl[i].exp_tx);
    end

    // Abort while waiting for the point test at code 8.
    fillAll('1);
    hold_code = 8;
    mode = 1'b0;
    i_en = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      tick();
      if (o_pt_start === 1'b1 && o_pi_step == 4'd8) found = 1'b1;
    end
    checkOutput("abort_reach_8", 32'(found), 32'd1);
    repeat (2) tick();
    i_en = 1'b0;
    tick();
    checkOutput("abort_busy", 32'(o_busy), 32'd0);
    checkOutput("abort_ack", 32'(o_test_ack), 32'd0);
    checkOutput("abort_pi", 32'(o_pi_step), 32'd0);
    checkOutput("abort_cv", 32'(o_center_valid), 32'd0);
    base = pt_count;
    busy_seen = 0;
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (o_busy !== 1'b0 || o_test_ack !== 1'b0) busy_seen++;
    end
    checkOutput("abort_no_start", 32'(pt_count - base), 32'd0);
    checkOutput("abort_stays_idle", 32'(busy_seen), 32'd0);
    hold_code = -1;

    // Synchronous reset while the block is evaluating code 5.
    fillAll('1);
    i_en = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      tick();
      if (i_pt_done === 1'b1 && o_pi_step == 4'd5) found = 1'b1;
    end
    checkOutput("rst_eval_reach", 32'(found), 32'd1);
    tick();
    rst = 1'b1;
    i_en = 1'b0;
    tick();
    checkOutput("rst_eval_pt_start", 32'(o_pt_start), 32'd0);
    checkOutput("rst_eval_pi", 32'(o_pi_step), 32'd0);
    checkOutput("rst_eval_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_eval_ack", 32'(o_test_ack), 32'd0);
    checkOutput("rst_eval_cv", 32'(o_center_valid), 32'd0);
    checkOutput("rst_eval_tx", 32'(o_tx_lanes_result), 32'd0);
    rst = 1'b0;
    repeat (2) tick();
    checkSweep("after_rst", 1'b0, 4'd7, 1'b1, 16'hFFFF);

    // Randomized sweeps against the window-search model.
    for (int i = 0; i < 8; i++) begin
      rm = 1'($urandom_range(0, 1));
      for (int c = 0; c < NCODES; c++) begin
        v = NL'($urandom);
        if ($urandom_range(0, 99) < 55) begin
          if (rm) v[0] = 1'b1;
          else v = '1;
        end else begin
          if (rm) v[0] = 1'b0;
          else v[$urandom_range(0, NL - 1)] = 1'b0;
        end
        vec_tbl[c] = v;
      end
      model(rm, mpi, mcv, mtx);
      checkSweep($sformatf("rand%0d", i), rm, mpi, mcv, mtx);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
